// File: rtl/debug_display_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : dbg_disp_pkg                                                   |
// | Brief   : Shared constants and the hex-to-7-segment glyph function for   |
// |           the debug display controller.                                  |
// | Contents: VIEW_TOP/VIEW_CU/VIEW_DP view codes, TOP_FIELDS (number of     |
// |           selectable top-view fields), hex2seg().                        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package dbg_disp_pkg;

   localparam logic [1:0] VIEW_TOP = 2'b00;
   localparam logic [1:0] VIEW_CU  = 2'b01;
   localparam logic [1:0] VIEW_DP  = 2'b10;

   // Top view selects index[8:6] in the range 0..TOP_FIELDS-1
   localparam int TOP_FIELDS = 6;

   // Active-low glyph, bit order {dp,g,f,e,d,c,b,a}; dp is always off here
   function automatic logic [7:0] hex2seg(input logic [3:0] nibble);
      logic [7:0] seg;
      case (nibble)
         4'h0:    seg = 8'hC0;
         4'h1:    seg = 8'hF9;
         4'h2:    seg = 8'hA4;
         4'h3:    seg = 8'hB0;
         4'h4:    seg = 8'h99;
         4'h5:    seg = 8'h92;
         4'h6:    seg = 8'h82;
         4'h7:    seg = 8'hF8;
         4'h8:    seg = 8'h80;
         4'h9:    seg = 8'h90;
         4'hA:    seg = 8'h88;
         4'hB:    seg = 8'h83;
         4'hC:    seg = 8'hC6;
         4'hD:    seg = 8'hA1;
         4'hE:    seg = 8'h86;
         default: seg = 8'h8E;
      endcase
      return seg;
   endfunction

endpackage
`default_nettype wire

// File: rtl/debug_display_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface: debug_display_ctrl_if                                         |
// | Brief    : Debug select / display data bus between the board controller  |
// |            and the core.                                                 |
// | Signals  : sel_out    [10:0] {view[1:0], index[8:0]} to the core         |
// |            disdata_in [31:0] debug word from the core (combinational     |
// |                              function of sel_out)                        |
// | Modports : master (controller side), slave (core side)                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface debug_display_ctrl_if;
   logic [10:0] sel_out;
   logic [31:0] disdata_in;

   modport master (output sel_out, input  disdata_in);
   modport slave  (input  sel_out, output disdata_in);
endinterface
`default_nettype wire

// File: rtl/debug_display_ctrl_btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : btn_debounce                                                   |
// | Brief   : Accepts a new level of an already-synchronised button only     |
// |           after it has differed from the accepted level for              |
// |           DEBOUNCE_CYCLES consecutive cycles; emits a one-cycle pulse on |
// |           each accepted 0->1 transition.                                 |
// | Ports   : clk     in  clock                                              |
// |           reset   in  async active-low reset                             |
// |           i_din   in  synchronised button level                          |
// |           o_pulse out one-cycle press pulse                              |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_din,
   output logic o_pulse
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_level;
   logic [CW-1:0] r_cnt;
   logic          r_pulse;

   // The counter only runs while the input disagrees with the accepted
   // level; any return to agreement throws the partial count away.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_level <= 1'b0;
         r_cnt   <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_pulse <= 1'b0;
         if (i_din == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == C_LAST) begin
            r_level <= i_din;
            r_cnt   <= '0;
            r_pulse <= i_din;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/debug_display_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : debug_display_ctrl                                             |
// | Brief   : Board-side partner of the core debug interface. Steps the      |
// |           debug select from buttons/switches, captures the returned word |
// |           once per display frame and scans it onto an 8-digit,           |
// |           active-low, multiplexed 7-segment display.                     |
// | Ports   : clk          in   clock                                        |
// |           reset        in   async active-low reset                       |
// |           i_btn_next   in   raw "next index" button                      |
// |           i_btn_prev   in   raw "previous index" button                  |
// |           i_view_sw    in   raw view switch (00/11 top, 01 CU, 10 DP)    |
// |           i_freeze_sw  in   raw freeze switch (1 = hold display)         |
// |           dbg          bus  sel_out / disdata_in to the core             |
// |           o_an         out  digit enables, active-low, [0] rightmost     |
// |           o_seg        out  segments, active-low, {dp,g,f,e,d,c,b,a}     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module debug_display_ctrl
   import dbg_disp_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int SCAN_DIV        = 100_000,
   parameter int INDEX_MAX       = 31
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_btn_next,
   input  logic                  i_btn_prev,
   input  logic [1:0]            i_view_sw,
   input  logic                  i_freeze_sw,
   debug_display_ctrl_if.master  dbg,
   output logic [7:0]            o_an,
   output logic [7:0]            o_seg
);

   localparam int              PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0]   C_PSC_TC  = PW'(SCAN_DIV - 1);
   localparam logic [8:0]      C_IDX_MAX = 9'(INDEX_MAX);
   localparam logic [2:0]      C_TOP_MAX = 3'(TOP_FIELDS - 1);

   // ---------------- input synchronisers ----------------
   logic [1:0] r_view_s1, r_view_s2;
   logic       r_frz_s1,  r_frz_s2;
   logic       r_next_s1, r_next_s2;
   logic       r_prev_s1, r_prev_s2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_view_s1 <= 2'b00;
         r_view_s2 <= 2'b00;
         r_frz_s1  <= 1'b0;
         r_frz_s2  <= 1'b0;
         r_next_s1 <= 1'b0;
         r_next_s2 <= 1'b0;
         r_prev_s1 <= 1'b0;
         r_prev_s2 <= 1'b0;
      end else begin
         r_view_s1 <= i_view_sw;
         r_view_s2 <= r_view_s1;
         r_frz_s1  <= i_freeze_sw;
         r_frz_s2  <= r_frz_s1;
         r_next_s1 <= i_btn_next;
         r_next_s2 <= r_next_s1;
         r_prev_s1 <= i_btn_prev;
         r_prev_s2 <= r_prev_s1;
      end
   end

   // ---------------- button debouncers ----------------
   logic w_next_p, w_prev_p;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
      .clk     (clk),
      .reset   (reset),
      .i_din   (r_next_s2),
      .o_pulse (w_next_p)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
      .clk     (clk),
      .reset   (reset),
      .i_din   (r_prev_s2),
      .o_pulse (w_prev_p)
   );

   // ---------------- view / index ----------------
   logic [1:0]  r_view;
   logic [8:0]  r_index;
   logic [10:0] r_sel;
   logic [1:0]  w_view_nxt;
   logic [8:0]  w_index_nxt;
   logic        w_top;

   // Code 11 is not a real view; it behaves like the top view
   assign w_top = (r_view == VIEW_TOP) || (r_view == 2'b11);

   always_comb begin
      w_view_nxt  = r_view;
      w_index_nxt = r_index;
      if (r_view_s2 != r_view) begin
         // A view change wins over any step arriving in the same cycle
         w_view_nxt  = r_view_s2;
         w_index_nxt = '0;
      end else if (w_next_p && !w_prev_p) begin
         if (w_top)
            w_index_nxt = {(r_index[8:6] >= C_TOP_MAX) ? 3'd0 : r_index[8:6] + 3'd1, 6'd0};
         else
            w_index_nxt = (r_index >= C_IDX_MAX) ? 9'd0 : r_index + 9'd1;
      end else if (w_prev_p && !w_next_p) begin
         if (w_top)
            w_index_nxt = {((r_index[8:6] == 3'd0) || (r_index[8:6] > C_TOP_MAX)) ?
                           C_TOP_MAX : r_index[8:6] - 3'd1, 6'd0};
         else
            w_index_nxt = ((r_index == 9'd0) || (r_index > C_IDX_MAX)) ?
                          C_IDX_MAX : r_index - 9'd1;
      end
   end

   // sel_out is loaded from the next-state value so it changes on the same
   // edge as view/index, one cycle after the step pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_view  <= VIEW_TOP;
         r_index <= '0;
         r_sel   <= '0;
      end else begin
         r_view  <= w_view_nxt;
         r_index <= w_index_nxt;
         r_sel   <= {w_view_nxt, w_index_nxt};
      end
   end

   assign dbg.sel_out = r_sel;

   // ---------------- scan and capture ----------------
   logic [PW-1:0] r_presc;
   logic          r_scan_on;
   logic [2:0]    r_digit;
   logic [31:0]   r_shadow;
   logic [7:0]    r_an;
   logic [7:0]    r_seg;
   logic          w_tc;
   logic          w_frame;
   logic [7:0]    w_glyph;

   assign w_tc    = (r_presc == C_PSC_TC);
   assign w_frame = w_tc && r_scan_on && (r_digit == 3'd7);
   assign w_glyph = hex2seg(r_shadow[{r_digit, 2'b00} +: 4]);

   // r_scan_on holds the display dark until the first terminal count, so
   // the first enabled digit after reset is digit 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_presc   <= '0;
         r_scan_on <= 1'b0;
         r_digit   <= 3'd0;
         r_shadow  <= '0;
         r_an      <= 8'hFF;
         r_seg     <= 8'hFF;
      end else begin
         if (w_tc) begin
            r_presc   <= '0;
            r_scan_on <= 1'b1;
            if (r_scan_on)
               r_digit <= r_digit + 3'd1;
         end else begin
            r_presc <= r_presc + 1'b1;
         end

         if (w_frame && !r_frz_s2)
            r_shadow <= dbg.disdata_in;

         if (r_scan_on) begin
            r_an  <= ~(8'd1 << r_digit);
            r_seg <= {~((r_digit == 3'd0) && r_frz_s2), w_glyph[6:0]};
         end
      end
   end

   assign o_an  = r_an;
   assign o_seg = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_debug_display_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_debug_display_ctrl                                          |
// | Brief   : Directed self-checking bench for debug_display_ctrl with       |
// |           DEBOUNCE_CYCLES=4, SCAN_DIV=2, INDEX_MAX=31.                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_debug_display_ctrl;

   logic        clk;
   logic        reset;
   logic        btn_next;
   logic        btn_prev;
   logic [1:0]  view_sw;
   logic        freeze_sw;
   logic [7:0]  an;
   logic [7:0]  seg;
   logic [31:0] core_word;

   int n_checks;
   int n_fail;

   debug_display_ctrl_if dbg_bus ();
   assign dbg_bus.disdata_in = core_word;

   debug_display_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .SCAN_DIV        (2),
      .INDEX_MAX       (31)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .i_btn_next  (btn_next),
      .i_btn_prev  (btn_prev),
      .i_view_sw   (view_sw),
      .i_freeze_sw (freeze_sw),
      .dbg         (dbg_bus.master),
      .o_an        (an),
      .o_seg       (seg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected patterns for 32'h1234ABCD, digit 0 first
   logic [7:0] exp_an  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
   logic [7:0] exp_seg [8] = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1 ns past the last one
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic nxt, input logic prv);
      btn_next = nxt;
      btn_prev = prv;
      step(8);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      step(10);
   endtask

   // Bounded search for digit 0 enabled; ends on a falling edge
   task automatic wait_an_fe(input string tag, input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (an == 8'hFE) break;
      end
      chk(tag, {24'd0, an}, 32'h0000_00FE);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b0;
      btn_next  = 1'b0;
      btn_prev  = 1'b0;
      view_sw   = 2'b00;
      freeze_sw = 1'b0;
      core_word = 32'h0;

      // ---- reset ----
      step(3);
      @(negedge clk);
      chk("rst_sel", {21'd0, dbg_bus.sel_out}, 32'h000);
      chk("rst_an",  {24'd0, an},  32'hFF);
      chk("rst_seg", {24'd0, seg}, 32'hFF);
      reset = 1'b1;
      wait_an_fe("rst_an_first", 3);
      step(1);

      // ---- top view stepping ----
      for (int k = 1; k <= 6; k++) begin
         logic [2:0] f;
         f = 3'(k % 6);
         press(1'b1, 1'b0);
         @(negedge clk);
         chk($sformatf("top_next_%0d", k), {21'd0, dbg_bus.sel_out}, {21'd0, 2'b00, f, 6'd0});
         step(1);
      end
      press(1'b0, 1'b1);
      @(negedge clk);
      chk("top_prev_wrap", {21'd0, dbg_bus.sel_out}, 32'h140);

      // ---- asynchronous reset mid-scan ----
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_sel", {21'd0, dbg_bus.sel_out}, 32'h000);
      chk("midrst_an",  {24'd0, an},  32'hFF);
      chk("midrst_seg", {24'd0, seg}, 32'hFF);
      @(negedge clk);
      reset = 1'b1;
      wait_an_fe("midrst_an_first", 3);
      step(1);

      // ---- bounce rejection ----
      btn_next = 1'b1;
      step(3);
      btn_next = 1'b0;
      step(10);
      @(negedge clk);
      chk("glitch_no_step", {21'd0, dbg_bus.sel_out}, 32'h000);
      step(1);
      btn_next = 1'b1;
      step(12);
      btn_next = 1'b0;
      step(10);
      @(negedge clk);
      chk("held_one_step", {21'd0, dbg_bus.sel_out}, 32'h040);
      step(1);

      // ---- CU view wrap ----
      view_sw = 2'b01;
      step(6);
      @(negedge clk);
      chk("cu_enter", {21'd0, dbg_bus.sel_out}, 32'h200);
      step(1);
      press(1'b0, 1'b1);
      @(negedge clk);
      chk("cu_prev_wrap", {21'd0, dbg_bus.sel_out}, 32'h21F);
      step(1);
      press(1'b1, 1'b0);
      @(negedge clk);
      chk("cu_next_wrap", {21'd0, dbg_bus.sel_out}, 32'h200);
      step(1);

      // ---- view change coinciding with a step pulse ----
      btn_next = 1'b1;
      step(4);
      view_sw = 2'b10;
      step(8);
      btn_next = 1'b0;
      step(10);
      @(negedge clk);
      chk("dp_enter_drop_step", {21'd0, dbg_bus.sel_out}, 32'h400);
      step(1);

      // ---- display scan ----
      core_word = 32'h1234ABCD;
      step(40);
      wait_an_fe("disp_sync", 20);
      for (int d = 0; d < 8; d++) begin
         chk($sformatf("disp_an_%0d", d),  {24'd0, an},  {24'd0, exp_an[d]});
         chk($sformatf("disp_seg_%0d", d), {24'd0, seg}, {24'd0, exp_seg[d]});
         repeat (2) @(negedge clk);
      end
      step(1);

      // ---- freeze ----
      freeze_sw = 1'b1;
      step(5);
      core_word = 32'h0;
      step(40);
      wait_an_fe("frz_sync", 20);
      chk("frz_seg_d0_dp", {24'd0, seg}, 32'h21);
      repeat (14) @(negedge clk);
      chk("frz_an_d7",  {24'd0, an},  32'h7F);
      chk("frz_seg_d7", {24'd0, seg}, 32'hF9);
      step(1);
      freeze_sw = 1'b0;
      step(20);
      wait_an_fe("unfrz_sync", 20);
      chk("unfrz_seg_d0", {24'd0, seg}, 32'hC0);
      repeat (2) @(negedge clk);
      chk("unfrz_seg_d1", {24'd0, seg}, 32'hC0);
      step(1);

      // ---- next and prev together ----
      press(1'b1, 1'b1);
      @(negedge clk);
      chk("both_no_step", {21'd0, dbg_bus.sel_out}, 32'h400);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
